// File: rtl/xbar_sw_alloc_pkg.sv
// Shared constants, lock record and pointer helper for the crossbar switch allocator.
package xbar_sw_alloc_pkg;

  localparam int XBAR_NUM_PORT = 5;
  localparam int PTR_W         = $clog2(XBAR_NUM_PORT);

  typedef struct packed {
    logic             locked;
    logic [PTR_W-1:0] owner;
  } lock_t;

  // Round-robin successor of the last winner, wrapping at n.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur, input int n);
    next_ptr = PTR_W'((32'(cur) + 32'd1) % 32'(n));
  endfunction

endpackage

// File: rtl/xbar_sw_alloc_if.sv
// Request/allocation bundle between the input buffers, the allocator and the crossbar.
interface xbar_sw_alloc_if
  import xbar_sw_alloc_pkg::*;
#(
  parameter int NUM_PORT = XBAR_NUM_PORT
);

  logic [NUM_PORT*NUM_PORT-1:0] req_vector;
  logic [NUM_PORT-1:0]          tail_vector;
  logic [NUM_PORT-1:0]          out_ready;
  logic [NUM_PORT*NUM_PORT-1:0] alloc_vector;
  logic [NUM_PORT-1:0]          grant;
  logic [NUM_PORT-1:0]          out_locked;

  modport master (
    output req_vector, tail_vector, out_ready,
    input  alloc_vector, grant, out_locked
  );

  modport slave (
    input  req_vector, tail_vector, out_ready,
    output alloc_vector, grant, out_locked
  );

endinterface

// File: rtl/xbar_sw_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr_i.
module xbar_sw_alloc_rr_arbiter
  import xbar_sw_alloc_pkg::*;
#(
  parameter int NUM_PORT = XBAR_NUM_PORT
) (
  input  logic [NUM_PORT-1:0] req_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [NUM_PORT-1:0] gnt_o
);

  localparam logic [NUM_PORT-1:0] ONE = {{(NUM_PORT-1){1'b0}}, 1'b1};

  logic [NUM_PORT-1:0] mask_s;
  logic [NUM_PORT-1:0] hi_s;

  // Requests at or above the pointer win first; otherwise wrap to the lowest request.
  assign mask_s = {NUM_PORT{1'b1}} << ptr_i;
  assign hi_s   = req_i & mask_s;
  assign gnt_o  = (|hi_s) ? (hi_s & (~hi_s + ONE)) : (req_i & (~req_i + ONE));

endmodule

// File: rtl/xbar_sw_alloc.sv
// Switch allocator for the 5-port crossbar: per-output round-robin with packet locking,
// registered select matrix and per-input grants.
module xbar_sw_alloc
  import xbar_sw_alloc_pkg::*;
#(
  parameter int NUM_PORT = XBAR_NUM_PORT
) (
  input  logic           clk,
  input  logic           reset_n,
  xbar_sw_alloc_if.slave bus
);

  localparam logic [NUM_PORT-1:0] ONE = {{(NUM_PORT-1){1'b0}}, 1'b1};

  logic [NUM_PORT-1:0]          req_raw_s;
  logic [NUM_PORT-1:0]          req_row_s [NUM_PORT];
  logic [NUM_PORT-1:0]          req_col_s [NUM_PORT];
  logic [NUM_PORT-1:0]          rr_gnt_s  [NUM_PORT];
  logic [NUM_PORT-1:0]          gnt_col_s [NUM_PORT];
  logic [NUM_PORT-1:0]          owner_sel_s;
  logic [PTR_W-1:0]             win_s;
  logic                         tail_w_s;
  logic [NUM_PORT-1:0]          out_locked_s;

  logic [PTR_W-1:0]             ptr_q  [NUM_PORT];
  logic [PTR_W-1:0]             ptr_d  [NUM_PORT];
  lock_t                        lock_q [NUM_PORT];
  lock_t                        lock_d [NUM_PORT];
  logic [NUM_PORT*NUM_PORT-1:0] alloc_q, alloc_d;
  logic [NUM_PORT-1:0]          grant_q, grant_d;

  // Keep only the lowest requested output per input, then transpose rows into columns.
  always_comb begin
    req_raw_s = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      req_raw_s    = bus.req_vector[j*NUM_PORT +: NUM_PORT];
      req_row_s[j] = req_raw_s & (~req_raw_s + ONE);
    end
    for (int k = 0; k < NUM_PORT; k++) begin
      for (int j = 0; j < NUM_PORT; j++) begin
        req_col_s[k][j] = req_row_s[j][k];
      end
    end
  end

  for (genvar k = 0; k < NUM_PORT; k++) begin : g_out
    xbar_sw_alloc_rr_arbiter #(
      .NUM_PORT (NUM_PORT)
    ) u_arb (
      .req_i (req_col_s[k]),
      .ptr_i (ptr_q[k]),
      .gnt_o (rr_gnt_s[k])
    );
    assign out_locked_s[k] = lock_q[k].locked;
  end

  // Per-output grant selection plus next pointer/lock state and the next select matrix.
  always_comb begin
    alloc_d     = '0;
    grant_d     = '0;
    owner_sel_s = '0;
    win_s       = '0;
    tail_w_s    = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) begin
      owner_sel_s = ONE << lock_q[k].owner;
      if (!bus.out_ready[k]) begin
        gnt_col_s[k] = '0;
      end else if (lock_q[k].locked) begin
        gnt_col_s[k] = req_col_s[k] & owner_sel_s;
      end else begin
        gnt_col_s[k] = rr_gnt_s[k];
      end

      win_s = '0;
      for (int j = 0; j < NUM_PORT; j++) begin
        win_s = win_s | (gnt_col_s[k][j] ? PTR_W'(j) : '0);
        alloc_d[j*NUM_PORT + k] = gnt_col_s[k][j];
      end
      tail_w_s = |(gnt_col_s[k] & bus.tail_vector);

      ptr_d[k]  = ptr_q[k];
      lock_d[k] = lock_q[k];
      if (|gnt_col_s[k]) begin
        lock_d[k].locked = ~tail_w_s;
        // Only a packet head moves the pointer; body and tail flits ride the existing lock.
        if (!lock_q[k].locked) begin
          ptr_d[k]        = next_ptr(win_s, NUM_PORT);
          lock_d[k].owner = win_s;
        end else begin
          ptr_d[k] = ptr_q[k];
        end
      end else begin
        lock_d[k] = lock_q[k];
      end
    end
    for (int j = 0; j < NUM_PORT; j++) begin
      grant_d[j] = |alloc_d[j*NUM_PORT +: NUM_PORT];
    end
  end

  // Allocation outputs, round-robin pointers and packet locks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_q <= '0;
      grant_q <= '0;
      for (int k = 0; k < NUM_PORT; k++) begin
        ptr_q[k]  <= '0;
        lock_q[k] <= '0;
      end
    end else begin
      alloc_q <= alloc_d;
      grant_q <= grant_d;
      for (int k = 0; k < NUM_PORT; k++) begin
        ptr_q[k]  <= ptr_d[k];
        lock_q[k] <= lock_d[k];
      end
    end
  end

  assign bus.alloc_vector = alloc_q;
  assign bus.grant        = grant_q;
  assign bus.out_locked   = out_locked_s;

endmodule
